// File: rtl/viterbi_dec.sv
// rtl/viterbi_dec.sv - K=3 rate-1/2 hard-decision Viterbi decoder, register-exchange survivors
// Defining VITERBI_ERRCNT_EN builds the saturating symbol-error counter behind err_cnt.
module viterbi_dec #(
    parameter int TB_LEN = 15,
    parameter int PM_W   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    input  logic        din_valid,
    output logic        dout,
    output logic        dout_valid,
    output logic [15:0] err_cnt
);
    localparam int CW = $clog2(TB_LEN + 1);
    localparam logic [PM_W-1:0] PM_INIT = PM_W'(1) << (PM_W - 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(TB_LEN);

    function automatic logic [1:0] bm_f(input logic [1:0] s, input logic u,
                                        input logic r0, input logic r1);
        logic g0;
        logic g1;
        g0 = u ^ s[1] ^ s[0];
        g1 = u ^ s[0];
        return {1'b0, r0 ^ g0} + {1'b0, r1 ^ g1};
    endfunction

    // Strict compare keeps the lowest index on ties.
    function automatic logic [1:0] best_f(input logic [3:0][PM_W-1:0] m);
        logic [1:0] b;
        b = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (m[i] < m[b]) b = 2'(i);
        end
        return b;
    endfunction

    logic                         phase_q, phase_d;
    logic                         r0_q, r0_d;
    logic [3:0][PM_W-1:0]         pm_q, pm_d;
    logic [3:0][TB_LEN-1:0]       surv_q, surv_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic                         pend_q, pend_d;
    logic                         dout_q, dout_d;
    logic                         dout_valid_q, dout_valid_d;

    logic                         step;
    logic [3:0][PM_W-1:0]         acs_pm;
    logic [3:0][TB_LEN-1:0]       acs_surv;
    logic [1:0]                   best_q;
`ifdef VITERBI_ERRCNT_EN
    logic [3:0][1:0]              acs_bm;
`endif

    assign step = phase_q & din_valid;

    // Next state {u, s[1]} has predecessors {ns[0], 0} and {ns[0], 1}; din is r1 on a step.
    for (genvar g = 0; g < 4; g++) begin : g_acs
        localparam logic [1:0] NS = 2'(g);
        localparam logic [1:0] PA = {NS[0], 1'b0};
        localparam logic [1:0] PB = {NS[0], 1'b1};
        localparam logic       U  = NS[1];
        logic [1:0]      bm_a, bm_b;
        logic [PM_W-1:0] m_a, m_b;
        logic            take_b;
        assign bm_a   = bm_f(PA, U, r0_q, din);
        assign bm_b   = bm_f(PB, U, r0_q, din);
        assign m_a    = pm_q[PA] + PM_W'(bm_a);
        assign m_b    = pm_q[PB] + PM_W'(bm_b);
        assign take_b = m_b < m_a;
        assign acs_pm[g]   = take_b ? m_b : m_a;
        assign acs_surv[g] = take_b ? {surv_q[PB][TB_LEN-2:0], U}
                                    : {surv_q[PA][TB_LEN-2:0], U};
`ifdef VITERBI_ERRCNT_EN
        assign acs_bm[g]   = take_b ? bm_b : bm_a;
`endif
    end

    assign best_q = best_f(pm_q);

    always_comb begin
        phase_d      = phase_q;
        r0_d         = r0_q;
        pm_d         = pm_q;
        surv_d       = surv_q;
        cnt_d        = cnt_q;
        pend_d       = 1'b0;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        if (din_valid) begin
            phase_d = ~phase_q;
            if (!phase_q) r0_d = din;
        end
        if (step) begin
            pm_d   = acs_pm;
            surv_d = acs_surv;
            if (acs_pm[0][PM_W-1] & acs_pm[1][PM_W-1] & acs_pm[2][PM_W-1] & acs_pm[3][PM_W-1]) begin
                for (int i = 0; i < 4; i++) pm_d[i][PM_W-1] = 1'b0;
            end
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
            pend_d = (cnt_d == CNT_MAX);
        end
        // Output is taken the edge after the step, from the freshly stored metrics.
        if (pend_q) begin
            dout_d       = surv_q[best_q][TB_LEN-1];
            dout_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q      <= 1'b0;
            r0_q         <= 1'b0;
            pm_q         <= {PM_INIT, PM_INIT, PM_INIT, {PM_W{1'b0}}};
            surv_q       <= '0;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            r0_q         <= r0_d;
            pm_q         <= pm_d;
            surv_q       <= surv_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

`ifdef VITERBI_ERRCNT_EN
    logic [15:0] err_q, err_d;
    logic [1:0]  best_new;

    // Normalisation clears the same bit in all four metrics, so ordering is unaffected.
    always_comb begin
        best_new = best_f(acs_pm);
        err_d    = err_q;
        if (step && acs_bm[best_new] != 2'd0 && err_q != 16'hFFFF) err_d = err_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 16'd0;
        else       err_q <= err_d;
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_viterbi_dec.sv
// tb/tb_viterbi_dec.sv - self-checking bench for viterbi_dec (TB_LEN=15, PM_W=6)
module tb_viterbi_dec;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        dout;
    logic        dout_valid;
    logic [15:0] err_cnt;

`ifdef VITERBI_ERRCNT_EN
    localparam int ERR_ON = 1;
`else
    localparam int ERR_ON = 0;
`endif

    viterbi_dec #(.TB_LEN(15), .PM_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit d; int at; } exp_t;
    typedef struct { bit [1:0] sym; bit exp_valid; bit exp_dout; } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vec[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && dout_valid) begin
            pulses++;
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("dout", 32'(dout), 32'(mon_e.d));
                check("latency", 32'(cyc), 32'(mon_e.at));
            end
        end
    end

    task automatic send_bit(input bit b, input int idle);
        din_valid = 1'b0;
        repeat (idle) begin
            @(posedge clk);
            #1;
        end
        din       = b;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic send_pair(input bit r0, input bit r1, input int idle_max,
                             input bit expv, input bit expd);
        exp_t e;
        send_bit(r0, int'($urandom_range(idle_max, 0)));
        send_bit(r1, int'($urandom_range(idle_max, 0)));
        if (expv) begin
            e.d  = expd;
            e.at = cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        #1;
        reset     = 1'b1;
        din_valid = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_dout_valid", 32'(dout_valid), 32'd0);
        check("reset_err_cnt", 32'(err_cnt), 32'd0);
        reset  = 1'b0;
        pulses = 0;
    endtask

    task automatic drain(input int exp_pulses, input int exp_err, input bit exp_last);
        repeat (4) @(posedge clk);
        #1;
        check("queue_empty", 32'(sb.size()), 32'd0);
        check("pulse_count", 32'(pulses), 32'(exp_pulses));
        check("err_cnt", 32'(err_cnt), 32'(exp_err));
        check("dout_hold", 32'(dout), 32'(exp_last));
    endtask

    task automatic run_table(input int flip, input int idle_max, input int npairs);
        bit r0;
        bit r1;
        for (int i = 0; i < npairs; i++) begin
            r0 = vec[i].sym[1];
            r1 = vec[i].sym[0];
            if (flip == 2 * i)     r0 = ~r0;
            if (flip == 2 * i + 1) r1 = ~r1;
            send_pair(r0, r1, idle_max, vec[i].exp_valid, vec[i].exp_dout);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [43:0] coded;
        logic [21:0] data_bits;
        bit [39:0]   rnd;
        bit [1:0]    enc_s;
        bit          u;

        coded     = {14'b11101111010111, 30'b0};
        data_bits = {7'b1001100, 15'b0};
        for (int i = 0; i < 22; i++) begin
            vec[i].sym       = coded[43 - 2 * i -: 2];
            vec[i].exp_valid = (i >= 14);
            vec[i].exp_dout  = (i >= 14) ? data_bits[21 - (i - 14)] : 1'b0;
        end

        // Reset and idle: no pulses without input.
        do_reset();
        repeat (10) @(posedge clk);
        #1;
        check("idle_pulses", 32'(pulses), 32'd0);

        // Clean stream, back-to-back bits.
        do_reset();
        run_table(-1, 0, 22);
        drain(8, 0, 1'b0);

        // Third coded bit flipped.
        do_reset();
        run_table(2, 0, 22);
        drain(8, ERR_ON, 1'b0);

        // Random idle gaps between every bit.
        do_reset();
        run_table(-1, 3, 22);
        drain(8, 0, 1'b0);

        // Reset mid-stream after 10 pairs plus a dangling g0 bit, then replay.
        do_reset();
        run_table(-1, 1, 10);
        send_bit(1'b1, 0);
        check("mid_pulses", 32'(pulses), 32'd0);
        do_reset();
        run_table(-1, 0, 22);
        drain(8, 0, 1'b0);

        // Long all-zero stream exercises normalisation-free steady state.
        do_reset();
        for (int i = 0; i < 64; i++) send_pair(1'b0, 1'b0, 0, i >= 14, 1'b0);
        drain(50, 0, 1'b0);

        // Random data through a reference encoder, with idle gaps.
        do_reset();
        rnd   = {$urandom(), $urandom()};
        enc_s = 2'b00;
        for (int i = 0; i < 40; i++) begin
            u = rnd[i];
            send_pair(u ^ enc_s[1] ^ enc_s[0], u ^ enc_s[0], 2, i >= 14,
                      (i >= 14) ? rnd[i - 14] : 1'b0);
            enc_s = {u, enc_s[1]};
        end
        drain(26, 0, rnd[25]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
